// File: rtl/tick_bcd_timer.sv
// BCD MM:SS timer advanced by rising edges of a divided clock sampled as data.
// Run/pause/clear FSM, alarm compare, and wrap or saturate-to-DONE at 59:59.
module tick_bcd_timer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          WRAP        = 1'b1
) (
    input  logic        I_CLK,
    input  logic        rst,
    input  logic        I_DIV_CLK,
    input  logic        I_START,
    input  logic        I_STOP,
    input  logic        I_CLEAR,
    input  logic        I_ALARM_EN,
    input  logic [15:0] I_ALARM_VAL,
    output logic [15:0] O_TIME,
    output logic        O_TICK,
    output logic        O_ALARM,
    output logic        O_WRAP,
    output logic        O_DONE,
    output logic        O_RUNNING
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick;
    logic [15:0]            time_q, time_d;
    logic [15:0]            inc_time;
    logic                   at_max;
    logic                   tick_q, tick_d;
    logic                   alarm_q, alarm_d;
    logic                   wrap_q, wrap_d;

    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_DIV_CLK};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign at_max = (time_q == 16'h5959);

    // Ripple-carry BCD increment: S1 0-9, S10 0-5, M1 0-9, M10 0-5.
    always_comb begin
        inc_time = time_q;
        if (time_q[3:0] == 4'd9) begin
            inc_time[3:0] = 4'd0;
            if (time_q[7:4] == 4'd5) begin
                inc_time[7:4] = 4'd0;
                if (time_q[11:8] == 4'd9) begin
                    inc_time[11:8] = 4'd0;
                    if (time_q[15:12] == 4'd5) begin
                        inc_time[15:12] = 4'd0;
                    end else begin
                        inc_time[15:12] = time_q[15:12] + 4'd1;
                    end
                end else begin
                    inc_time[11:8] = time_q[11:8] + 4'd1;
                end
            end else begin
                inc_time[7:4] = time_q[7:4] + 4'd1;
            end
        end else begin
            inc_time[3:0] = time_q[3:0] + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        alarm_d = 1'b0;
        wrap_d  = 1'b0;
        if (I_CLEAR) begin
            state_d = ST_IDLE;
            time_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (I_START) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (I_STOP) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (at_max && !WRAP) begin
                            state_d = ST_DONE;
                        end else begin
                            time_d  = inc_time;
                            tick_d  = 1'b1;
                            alarm_d = I_ALARM_EN && (inc_time == I_ALARM_VAL);
                            wrap_d  = at_max;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (I_START) state_d = ST_RUN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
            wrap_q  <= wrap_d;
        end
    end

    assign O_TIME    = time_q;
    assign O_TICK    = tick_q;
    assign O_ALARM   = alarm_q;
    assign O_WRAP    = wrap_q;
    assign O_DONE    = (state_q == ST_DONE);
    assign O_RUNNING = (state_q == ST_RUN);

endmodule
